fifo_rd_stream_adapter: RTL and testbench

Read-side consumer for the gray-pointer async FIFO. Runs in the read clock domain and drives the FIFO read port (rd_en/empty/data_out, one-cycle read latency). Converts FIFO reads into a valid/ready stream with a 2-entry skid buffer, sustaining one beat per cycle under continuous ready. Frames the stream into fixed-length packets (m_last) and keeps a delivered-beat counter for status.

---
 rtl/fifo_rd_stream_adapter.sv | 89 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: pulls words from the async FIFO read port and presents them as a
// valid/ready stream through a 2-entry skid buffer, framed into PKT_LEN-beat packets.
module fifo_rd_stream_adapter #(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk_rd,
    input  logic              rd_reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [IDX_W-1:0]  pkt_idx_q, pkt_idx_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic       pop;
    logic [1:0] fill_after;
    logic [1:0] keep;

    always_comb begin
        pop        = (occ_q != 2'd0) & m_ready;
        // Entries committed once this cycle's pop and the in-flight read land.
        fill_after = occ_q + {1'b0, pend_q} - {1'b0, pop};
        keep       = occ_q - {1'b0, pop};

        fifo_rd_en = rd_reset_n & enable & ~fifo_empty & (fill_after < 2'd2);
        pend_d     = fifo_rd_en;
        occ_d      = fill_after;

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (pend_q) begin
            if (keep == 2'd0) begin
                buf0_d = fifo_data;
            end else begin
                buf1_d = fifo_data;
            end
        end

        pkt_idx_d  = pkt_idx_q;
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            pkt_idx_d  = (pkt_idx_q == IDX_LAST) ? '0 : pkt_idx_q + 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_rd or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            occ_q      <= 2'd0;
            pend_q     <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            pkt_idx_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            pkt_idx_q  <= pkt_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf0_q;
    assign m_last   = m_valid & (pkt_idx_q == IDX_LAST);
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: FIFO read-port model, in-order scoreboard,
// a cycle table for the basic transfer and directed corner-case sequences.
module tb_fifo_rd_stream_adapter;

    logic       clk_rd = 1'b0;
    logic       rd_reset_n;
    logic       enable;
    logic       m_ready;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;

    logic        rd_en0, valid0, last0;
    logic [7:0]  data0;
    logic [3:0]  cnt0;
    logic        rd_en1, valid1, last1;
    logic [7:0]  data1;
    logic [15:0] cnt1;

    always #5 clk_rd = ~clk_rd;

    fifo_rd_stream_adapter #(.DATA_W(8), .PKT_LEN(4), .CNT_W(4)) dut0 (
        .clk_rd(clk_rd), .rd_reset_n(rd_reset_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd_en0),
        .m_data(data0), .m_valid(valid0), .m_ready(m_ready), .m_last(last0),
        .beat_cnt(cnt0)
    );

    fifo_rd_stream_adapter #(.DATA_W(8), .PKT_LEN(1), .CNT_W(16)) dut1 (
        .clk_rd(clk_rd), .rd_reset_n(rd_reset_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd_en1),
        .m_data(data1), .m_valid(valid1), .m_ready(m_ready), .m_last(last1),
        .beat_cnt(cnt1)
    );

    typedef struct {
        logic       en;
        logic       rdy;
        logic       exp_rd;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic [3:0] exp_cnt;
    } vec_t;

    logic [7:0] fq[$];
    logic [7:0] pq[$];
    logic [7:0] exp_q[$];

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int del_cnt  = 0;
    int last_cnt = 0;
    int mdl_beats = 0;
    int mdl_idx   = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        pq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk_rd);
        #1;
    endtask

    // FIFO read port: registered data_out, pushes become visible on the next edge.
    always @(posedge clk_rd) begin
        if (rd_en0 && fq.size() != 0) begin
            fifo_data <= fq.pop_front();
        end
        while (pq.size() != 0) fq.push_back(pq.pop_front());
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk_rd) begin
        if (!rd_reset_n) begin
            // Everything already read out of the FIFO is lost on reset.
            while (exp_q.size() > fq.size() + pq.size()) void'(exp_q.pop_front());
            mdl_beats = 0;
            mdl_idx   = 0;
            prev_hold = 1'b0;
        end else begin
            check("rd_en_while_empty", {31'd0, rd_en0 & fifo_empty}, 0);
            check("occ_pend_bound", {31'd0, (dut0.occ_q + dut0.pend_q) <= 2}, 1);
            check("beat_cnt", {28'd0, cnt0}, mdl_beats % 16);
            check("beat_cnt_p1", {16'd0, cnt1}, mdl_beats % 65536);
            check("last_p1", {31'd0, last1}, {31'd0, valid1});
            if (prev_hold && valid0) check("hold_data", {24'd0, data0}, {24'd0, prev_data});
            if (valid0 && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {24'd0, data0}, 32'hffff_ffff);
                end else begin
                    check("data", {24'd0, data0}, {24'd0, exp_q.pop_front()});
                end
                check("last", {31'd0, last0}, (mdl_idx == 3) ? 1 : 0);
                mdl_idx = (mdl_idx + 1) % 4;
                mdl_beats++;
                del_cnt++;
                if (last0) last_cnt++;
            end
            prev_hold = valid0 & ~m_ready;
            prev_data = data0;
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || valid0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic idle_reset();
        rd_reset_n = 1'b0;
        tick();
        tick();
        rd_reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   d0, l0, pulses;
        logic [7:0] v;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 4'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 4'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 4'd2};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 4'd3};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4};

        rd_reset_n = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        #12;
        check("rst_rd_en", {31'd0, rd_en0}, 0);
        check("rst_valid", {31'd0, valid0}, 0);
        check("rst_data", {24'd0, data0}, 0);
        check("rst_last", {31'd0, last0}, 0);
        check("rst_cnt", {28'd0, cnt0}, 0);
        tick();
        tick();
        rd_reset_n = 1'b1;
        tick();

        // Basic transfer, cycle by cycle.
        for (int i = 1; i <= 4; i++) push(8'(i));
        tick();
        for (int i = 0; i < 7; i++) begin
            enable  = tbl[i].en;
            m_ready = tbl[i].rdy;
            @(negedge clk_rd);
            check($sformatf("tbl%0d_rd_en", i), {31'd0, rd_en0}, {31'd0, tbl[i].exp_rd});
            check($sformatf("tbl%0d_valid", i), {31'd0, valid0}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_data", i), {24'd0, data0}, {24'd0, tbl[i].exp_data});
            check($sformatf("tbl%0d_last", i), {31'd0, last0}, {31'd0, tbl[i].exp_last});
            check($sformatf("tbl%0d_cnt", i), {28'd0, cnt0}, {28'd0, tbl[i].exp_cnt});
            tick();
        end

        // Backpressure: only two reads may be issued into a stalled buffer.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        tick();
        d0     = del_cnt;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_rd);
            if (rd_en0) pulses++;
            tick();
        end
        check("bp_pulses", pulses, 2);
        check("bp_valid", {31'd0, valid0}, 1);
        check("bp_head", {24'd0, data0}, 32'h10);
        m_ready = 1'b1;
        drain(100);
        check("bp_delivered", del_cnt - d0, 8);

        // Streaming at full rate.
        v = 8'h20;
        for (int i = 0; i < 3; i++) begin push(v); v++; end
        tick();
        for (int i = 0; i < 40; i++) begin
            if (fq.size() + pq.size() < 4) begin push(v); v++; end
            @(negedge clk_rd);
            if (i >= 2) begin
                check("stream_rd_en", {31'd0, rd_en0}, 1);
                check("stream_valid", {31'd0, valid0}, 1);
            end
            tick();
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        drain(100);

        // Enable dropped right after a read is issued.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
        tick();
        d0     = del_cnt;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_rd);
            check("endrop_rd_en", {31'd0, rd_en0}, 0);
            tick();
        end
        check("endrop_pending", del_cnt - d0, 1);
        enable = 1'b1;
        drain(100);

        // Packet framing from a clean index, random backpressure.
        idle_reset();
        l0 = last_cnt;
        d0 = del_cnt;
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        tick();
        for (int n = 0; n < 300 && (del_cnt - d0) < 10; n++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b0;
        check("frame_beats", del_cnt - d0, 10);
        check("frame_lasts", last_cnt - l0, 2);
        check("frame_idx_end", {30'd0, dut0.pkt_idx_q}, 2);

        // beat_cnt wrap on the 4-bit counter.
        idle_reset();
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        tick();
        m_ready = 1'b1;
        drain(100);
        check("wrap_cnt4", {28'd0, cnt0}, 1);
        check("wrap_cnt16", {16'd0, cnt1}, 17);

        // Reset with the buffer full.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_valid", {31'd0, valid0}, 1);
        rd_reset_n = 1'b0;
        #1;
        check("mid_rst_rd_en", {31'd0, rd_en0}, 0);
        check("mid_rst_valid", {31'd0, valid0}, 0);
        check("mid_rst_data", {24'd0, data0}, 0);
        check("mid_rst_last", {31'd0, last0}, 0);
        check("mid_rst_cnt", {28'd0, cnt0}, 0);
        check("mid_rst_cnt_p1", {16'd0, cnt1}, 0);
        tick();
        tick();
        rd_reset_n = 1'b1;
        check("post_rst_next", {24'd0, exp_q[0]}, 32'h62);
        m_ready = 1'b1;
        drain(100);
        check("post_rst_cnt", {28'd0, cnt0}, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
